// File: rtl/sram_sp_port_arbiter.sv
// Single-port SRAM arbiter: write-priority with a bounded write burst, plus a
// 2-entry return FIFO so the read consumer can apply backpressure.
module sram_sp_port_arbiter #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned MAX_WR_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_data_ready,
  output logic [ADDR_W-1:0] addr_to_mem,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              wen_to_mem,
  output logic              ren_to_mem,
  input  logic [DATA_W-1:0] data_from_mem
);

  localparam int unsigned BW = $clog2(MAX_WR_BURST + 1);

  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] fifo_tail;
  logic [1:0]        fifo_cnt;
  logic              inflight;
  logic [BW-1:0]     wr_burst_cnt;

  logic              active;
  logic              pop;
  logic [2:0]        occupancy;
  logic              rd_elig;
  logic              burst_full;

  assign active        = clk_en & rst_n & ~flush;
  assign rd_data       = fifo_head;
  assign rd_data_valid = (fifo_cnt != 2'd0);
  assign pop           = rd_data_valid & rd_data_ready;

  // Count the in-flight read as occupied so its return always has a slot.
  assign occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_elig    = rd_req & (occupancy < 3'd2);
  assign burst_full = (wr_burst_cnt == BW'(MAX_WR_BURST));

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (active) begin
      if (wr_req && !(rd_elig && burst_full)) wr_gnt = 1'b1;
      else if (rd_elig)                       rd_gnt = 1'b1;
    end
  end

  always_comb begin
    addr_to_mem = '0;
    data_to_mem = '0;
    wen_to_mem  = 1'b0;
    ren_to_mem  = 1'b0;
    if (wr_gnt) begin
      wen_to_mem  = 1'b1;
      addr_to_mem = wr_addr;
      data_to_mem = wr_data;
    end else if (rd_gnt) begin
      ren_to_mem  = 1'b1;
      addr_to_mem = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      fifo_head    <= '0;
      fifo_tail    <= '0;
      fifo_cnt     <= '0;
      inflight     <= 1'b0;
      wr_burst_cnt <= '0;
    end else if (clk_en) begin
      inflight <= rd_gnt;

      if (rd_gnt || !rd_elig)                 wr_burst_cnt <= '0;
      else if (wr_gnt && !burst_full)         wr_burst_cnt <= wr_burst_cnt + BW'(1);

      // Shift FIFO: tail is kept at zero whenever it holds no entry, so a pop
      // that empties the FIFO leaves the head register at zero.
      case ({inflight, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo_head <= data_from_mem;
          else                  fifo_tail <= data_from_mem;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_head <= fifo_tail;
          fifo_tail <= '0;
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd2) begin
            fifo_head <= fifo_tail;
            fifo_tail <= data_from_mem;
          end else begin
            fifo_head <= data_from_mem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
